menu_configuracao: RTL and testbench

MENU_CONFIGURACAO -- requirements
Module: menu_configuracao

---
 rtl/menu_configuracao.sv | 187 ++++++++++++++++++
 tb/tb_menu_configuracao.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/menu_configuracao.sv
// menu_configuracao: game-setup menu FSM.
// Walks the player through difficulty (modo), lives (vidas) and map (mapa)
// selection, holds restaura high for 16 cycles while the datapath loads the
// selected map, then signals jogo_ativo until fim_jogo returns it to idle.
// Optional build macro: MENU_WRAP_EN -- selections wrap around at their
// range limits instead of saturating.
module menu_configuracao (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [1:0] controle_vertical,
  input  logic       confirma,
  input  logic       fim_jogo,
  output logic [1:0] modo,
  output logic [1:0] vidas,
  output logic [1:0] mapa,
  output logic       restaura,
  output logic       jogo_ativo,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    REPOUSO   = 4'd0,
    SEL_MODO  = 4'd1,
    SEL_VIDAS = 4'd2,
    SEL_MAPA  = 4'd3,
    CARREGA   = 4'd4,
    PRONTO    = 4'd5
  } estado_t;

  localparam logic [1:0] MODO_MIN  = 2'd0;
  localparam logic [1:0] MODO_MAX  = 2'd2;
  localparam logic [1:0] VIDAS_MIN = 2'd1;
  localparam logic [1:0] VIDAS_MAX = 2'd3;
  localparam logic [1:0] MAPA_MIN  = 2'd0;
  localparam logic [1:0] MAPA_MAX  = 2'd3;

  localparam logic [1:0] CV_SOBE  = 2'b01;
  localparam logic [1:0] CV_DESCE = 2'b10;

  localparam logic [3:0] CONT_ULTIMO = 4'd15;

  estado_t    estado_q, estado_d;
  logic [1:0] modo_q, modo_d;
  logic [1:0] vidas_q, vidas_d;
  logic [1:0] mapa_q, mapa_d;
  logic [3:0] cont_q, cont_d;
  logic [1:0] cv_prev_q, cv_prev_d;
  logic       cf_prev_q, cf_prev_d;

  logic       borda_sobe;
  logic       borda_desce;
  logic       borda_confirma;

  // One-step adjustment of a selection field: saturating by default,
  // wrapping when MENU_WRAP_EN is defined. Up takes precedence over down,
  // though the two can never be asserted together.
  function automatic logic [1:0] ajusta(
    input logic [1:0] valor,
    input logic [1:0] minimo,
    input logic [1:0] maximo,
    input logic       sobe,
    input logic       desce
  );
    logic [1:0] r;
    r = valor;
    if (sobe) begin
`ifdef MENU_WRAP_EN
      r = (valor == maximo) ? minimo : valor + 2'd1;
`else
      if (valor != maximo) r = valor + 2'd1;
`endif
    end else if (desce) begin
`ifdef MENU_WRAP_EN
      r = (valor == minimo) ? maximo : valor - 2'd1;
`else
      if (valor != minimo) r = valor - 2'd1;
`endif
    end
    return r;
  endfunction

  // Edge detection: live inputs compared against last cycle's samples.
  always_comb begin
    borda_sobe     = (controle_vertical == CV_SOBE)  && (cv_prev_q != CV_SOBE);
    borda_desce    = (controle_vertical == CV_DESCE) && (cv_prev_q != CV_DESCE);
    borda_confirma = confirma && !cf_prev_q;
  end

  // Next-state and field-update logic; confirm-edge wins over up/down.
  always_comb begin
    estado_d  = estado_q;
    modo_d    = modo_q;
    vidas_d   = vidas_q;
    mapa_d    = mapa_q;
    cont_d    = cont_q;
    cv_prev_d = controle_vertical;
    cf_prev_d = confirma;

    case (estado_q)
      REPOUSO: begin
        if (iniciar) begin
          estado_d = SEL_MODO;
          modo_d   = MODO_MIN;
          vidas_d  = VIDAS_MIN;
          mapa_d   = MAPA_MIN;
        end
      end

      SEL_MODO: begin
        if (borda_confirma) begin
          estado_d = SEL_VIDAS;
        end else begin
          modo_d = ajusta(modo_q, MODO_MIN, MODO_MAX, borda_sobe, borda_desce);
        end
      end

      SEL_VIDAS: begin
        if (borda_confirma) begin
          estado_d = SEL_MAPA;
        end else begin
          vidas_d = ajusta(vidas_q, VIDAS_MIN, VIDAS_MAX, borda_sobe, borda_desce);
        end
      end

      SEL_MAPA: begin
        if (borda_confirma) begin
          estado_d = CARREGA;
          cont_d   = '0;
        end else begin
          mapa_d = ajusta(mapa_q, MAPA_MIN, MAPA_MAX, borda_sobe, borda_desce);
        end
      end

      CARREGA: begin
        if (cont_q == CONT_ULTIMO) begin
          estado_d = PRONTO;
          cont_d   = '0;
        end else begin
          cont_d = cont_q + 4'd1;
        end
      end

      PRONTO: begin
        if (fim_jogo) begin
          estado_d = REPOUSO;
        end
      end

      default: begin
        estado_d = REPOUSO;
      end
    endcase
  end

  // State, selection fields, load counter and input history registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= REPOUSO;
      modo_q    <= MODO_MIN;
      vidas_q   <= VIDAS_MIN;
      mapa_q    <= MAPA_MIN;
      cont_q    <= '0;
      cv_prev_q <= '0;
      cf_prev_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      modo_q    <= modo_d;
      vidas_q   <= vidas_d;
      mapa_q    <= mapa_d;
      cont_q    <= cont_d;
      cv_prev_q <= cv_prev_d;
      cf_prev_q <= cf_prev_d;
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    modo       = modo_q;
    vidas      = vidas_q;
    mapa       = mapa_q;
    restaura   = (estado_q == CARREGA);
    jogo_ativo = (estado_q == PRONTO);
    db_estado  = estado_q;
  end

endmodule

// File: tb/tb_menu_configuracao.sv
// Scoreboard bench for menu_configuracao: the driver pushes the expected
// outputs for each cycle from a behavioural model, a monitor pops and
// compares them after every rising edge; directed checks use constants.
module tb_menu_configuracao;

  logic       clock;
  logic       reset;
  logic       iniciar;
  logic [1:0] controle_vertical;
  logic       confirma;
  logic       fim_jogo;
  logic [1:0] modo;
  logic [1:0] vidas;
  logic [1:0] mapa;
  logic       restaura;
  logic       jogo_ativo;
  logic [3:0] db_estado;

  menu_configuracao dut (
    .clock             (clock),
    .reset             (reset),
    .iniciar           (iniciar),
    .controle_vertical (controle_vertical),
    .confirma          (confirma),
    .fim_jogo          (fim_jogo),
    .modo              (modo),
    .vidas             (vidas),
    .mapa              (mapa),
    .restaura          (restaura),
    .jogo_ativo        (jogo_ativo),
    .db_estado         (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] st;
    logic [1:0] modo;
    logic [1:0] vidas;
    logic [1:0] mapa;
    logic       rest;
    logic       jogo;
  } snap_t;

  snap_t exp_q[$];
  int    n_chk = 0;
  int    n_err = 0;

`ifdef MENU_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  // Reference model: menu position, selections, remaining load cycles,
  // and the last applied vertical / confirm inputs.
  int m_st, m_modo, m_vidas, m_mapa, m_left, m_pcv, m_pcf;

  function automatic int bump(input int v, input int lo, input int hi, input int dir);
    int n;
    n = v + dir;
    if (n > hi) n = WRAP ? lo : hi;
    if (n < lo) n = WRAP ? hi : lo;
    return n;
  endfunction

  task automatic model_reset();
    m_st = 0; m_modo = 0; m_vidas = 1; m_mapa = 0;
    m_left = 0; m_pcv = 0; m_pcf = 0;
  endtask

  task automatic model_step(input int ini, input int cv, input int cf, input int fim);
    int dir;
    bit ce;
    dir = 0;
    if (cv == 1 && m_pcv != 1) dir = 1;
    if (cv == 2 && m_pcv != 2) dir = -1;
    ce = (cf != 0) && (m_pcf == 0);
    case (m_st)
      0: if (ini != 0) begin m_st = 1; m_modo = 0; m_vidas = 1; m_mapa = 0; end
      1: if (ce) m_st = 2; else m_modo  = bump(m_modo, 0, 2, dir);
      2: if (ce) m_st = 3; else m_vidas = bump(m_vidas, 1, 3, dir);
      3: if (ce) begin m_st = 4; m_left = 16; end else m_mapa = bump(m_mapa, 0, 3, dir);
      4: begin m_left = m_left - 1; if (m_left == 0) m_st = 5; end
      5: if (fim != 0) m_st = 0;
      default: m_st = 0;
    endcase
    m_pcv = cv;
    m_pcf = cf;
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st    = 4'(m_st);
    s.modo  = 2'(m_modo);
    s.vidas = 2'(m_vidas);
    s.mapa  = 2'(m_mapa);
    s.rest  = (m_st == 4);
    s.jogo  = (m_st == 5);
    return s;
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Apply inputs for the coming rising edge and queue the expected result.
  task automatic drive(input int ini, input int cv, input int cf, input int fim);
    iniciar           = (ini != 0);
    controle_vertical = 2'(cv);
    confirma          = (cf != 0);
    fim_jogo          = (fim != 0);
    model_step(ini, cv, cf, fim);
    exp_q.push_back(model_snap());
  endtask

  task automatic tick(input int ini, input int cv, input int cf, input int fim);
    @(negedge clock);
    drive(ini, cv, cf, fim);
  endtask

  task automatic settle();
    @(posedge clock);
    #2;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_estado"}, db_estado, 0);
    chk({tag, "_restaura"}, restaura, 0);
    chk({tag, "_jogo_ativo"}, jogo_ativo, 0);
    chk({tag, "_modo"}, modo, 0);
    chk({tag, "_vidas"}, vidas, 1);
    chk({tag, "_mapa"}, mapa, 0);
  endtask

  // Asynchronous reset mid-cycle: outputs must change without a clock edge.
  task automatic do_reset(input string tag);
    @(negedge clock);
    reset = 1'b1;
    iniciar = 1'b0; controle_vertical = 2'b00; confirma = 1'b0; fim_jogo = 1'b0;
    model_reset();
    #1;
    check_reset_values(tag);
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 0, 0);
  endtask

  // Monitor: compare DUT outputs with the queued expectation after each edge.
  initial begin
    snap_t e;
    snap_t a;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {db_estado, modo, vidas, mapa, restaura, jogo_ativo};
        n_chk++;
        if (a !== e) begin
          n_err++;
          $display("FAIL cycle_outputs: got st=%0d modo=%0d vidas=%0d mapa=%0d rest=%0d jogo=%0d expected st=%0d modo=%0d vidas=%0d mapa=%0d rest=%0d jogo=%0d at %0t",
                   a.st, a.modo, a.vidas, a.mapa, a.rest, a.jogo,
                   e.st, e.modo, e.vidas, e.mapa, e.rest, e.jogo, $time);
        end
      end
    end
  end

  initial begin
    int n_rest;
    reset = 1'b0;
    iniciar = 1'b0; controle_vertical = 2'b00; confirma = 1'b0; fim_jogo = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_reset_values("por");
    @(negedge clock);
    reset = 1'b0;
    drive(0, 0, 0, 0);

    // Start, one up pulse, confirm into lives selection.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    settle();
    chk("s1_estado", db_estado, 2);
    chk("s1_modo", modo, 1);

    // Two 10-cycle up pulses separated by idle, confirm into map selection.
    repeat (10) tick(0, 1, 0, 0);
    repeat (3)  tick(0, 0, 0, 0);
    repeat (10) tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    settle();
    chk("s2_vidas", vidas, 3);
    chk("s2_estado", db_estado, 3);

    // One up pulse, confirm, count restaura cycles, reach PRONTO.
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 1, 0);
    settle();
    chk("s3_mapa", mapa, 1);
    chk("s3_estado_carrega", db_estado, 4);
    n_rest = restaura ? 1 : 0;
    repeat (19) begin
      tick(0, 0, 0, 0);
      settle();
      if (restaura) n_rest++;
    end
    chk("s3_restaura_cycles", n_rest, 16);
    chk("s3_jogo_ativo", jogo_ativo, 1);
    chk("s3_estado_pronto", db_estado, 5);
    tick(1, 1, 1, 0);
    settle();
    chk("s3_pronto_ignores_inputs", db_estado, 5);
    tick(0, 0, 0, 1);
    settle();
    chk("s3_fim_estado", db_estado, 0);
    chk("s3_keep_modo", modo, 1);
    chk("s3_keep_vidas", vidas, 3);
    chk("s3_keep_mapa", mapa, 1);
    tick(0, 0, 0, 0);

    // Held up steps once; then down to 0 and three pulses to the limit.
    tick(1, 0, 0, 0);
    tick(0, 0, 0, 0);
    repeat (500) tick(0, 1, 0, 0);
    settle();
    chk("s4_hold_modo", modo, 1);
    tick(0, 0, 0, 0);
    tick(0, 2, 0, 0);
    tick(0, 0, 0, 0);
    repeat (3) begin
      tick(0, 1, 0, 0);
      tick(0, 0, 0, 0);
    end
    settle();
    chk("s4_modo_limit", modo, WRAP ? 0 : 2);

    // Confirm and up in the same cycle: advance, field unchanged.
    tick(0, 0, 1, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 1, 0);
    tick(0, 0, 0, 0);
    settle();
    chk("s5_estado", db_estado, 3);
    chk("s5_vidas", vidas, 1);
    tick(0, 2, 0, 0);
    tick(0, 0, 0, 0);
    settle();
    chk("s5_mapa_low_limit", mapa, WRAP ? 3 : 0);

    // Reset during restaura cycle 8.
    tick(0, 0, 1, 0);
    repeat (7) tick(0, 0, 0, 0);
    settle();
    chk("s6_still_carrega", restaura, 1);
    do_reset("s6_mid_load");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd");
      end else begin
        tick(($urandom_range(0, 9) == 0) ? 1 : 0,
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) == 0) ? 1 : 0,
             ($urandom_range(0, 19) == 0) ? 1 : 0);
      end
    end

    repeat (2) @(posedge clock);
    #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
